// File: rtl/locked_reg_reader.sv
// ---------------------------------------------------------------------------
// locked_reg_reader
//
// Purpose:
//   Single-outstanding read port over a small bank of protected registers.
//   Each register has a sticky lock bit. A read of a locked register returns
//   zero data and an error flag instead of the register contents. A read
//   request is accepted in IDLE. The lock is evaluated in CHECK. The
//   response is held in RESP until the consumer acknowledges it.
//
// Ports:
//   Clk            in   single clock, all state updates on its rising edge
//   resetn         in   synchronous active-low reset
//   reg_data       in   NUM_REGS*DATA_W; register i at [i*DATA_W +: DATA_W]
//   Lock           in   NUM_REGS; per-register lock request (sets sticky bit)
//   scan_mode      in   mode indicator, deliberately has no effect
//   debug_unlocked in   mode indicator, deliberately has no effect
//   test_mode      in   mode indicator, deliberately has no effect
//   rd_req         in   read request, accepted when rd_req & rd_ready
//   rd_addr        in   2-bit register index, sampled with the request
//   rd_ready       out  high only in IDLE
//   rd_valid       out  response valid (RESP state)
//   rd_data        out  DATA_W response data (zero when denied or idle)
//   rd_err         out  response denied because the register is locked
//   rd_ack         in   consumer accepts the response when rd_valid & rd_ack
//   lock_status    out  NUM_REGS registered sticky lock bits
//   deny_count     out  8-bit saturating count of denied reads (READ_AUDIT_EN only)
//   violation      out  sticky "a read was denied" flag (READ_AUDIT_EN only)
//
// Build option:
//   READ_AUDIT_EN  when defined, adds the deny_count / violation audit outputs.
// ---------------------------------------------------------------------------
module locked_reg_reader #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4
) (
    input  logic                         Clk,
    input  logic                         resetn,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_data,
    input  logic [NUM_REGS-1:0]          Lock,
    input  logic                         scan_mode,
    input  logic                         debug_unlocked,
    input  logic                         test_mode,
    input  logic                         rd_req,
    input  logic [1:0]                   rd_addr,
    output logic                         rd_ready,
    output logic                         rd_valid,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_err,
    input  logic                         rd_ack,
    output logic [NUM_REGS-1:0]          lock_status
`ifdef READ_AUDIT_EN
    ,
    output logic [7:0]                   deny_count,
    output logic                         violation
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]          r_state;
    logic [NUM_REGS-1:0] r_lock;
    logic [1:0]          r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_err;

    logic [DATA_W-1:0]   w_regs [NUM_REGS];
    logic                w_eff_lock;
    logic                w_unused_modes;

    // Mode indicators must never be able to bypass a lock. They are consumed
    // here only so that no logic depends on them.
    assign w_unused_modes = scan_mode ^ debug_unlocked ^ test_mode;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_unpack
            assign w_regs[gi] = reg_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // A lock request arriving in the same cycle as the check also denies
    // the read, so the registered bit alone is not enough.
    assign w_eff_lock = r_lock[r_addr] | Lock[r_addr];

    always_ff @(posedge Clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_lock  <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_lock <= r_lock | Lock;
            case (r_state)
                IDLE: begin
                    if (rd_req) begin
                        r_addr  <= rd_addr;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    r_err   <= w_eff_lock;
                    r_data  <= w_eff_lock ? '0 : w_regs[r_addr];
                    r_state <= RESP;
                end
                RESP: begin
                    // Clear the captured response so nothing lingers on
                    // rd_data once the transaction is over.
                    if (rd_ack) begin
                        r_data  <= '0;
                        r_err   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_ready    = (r_state == IDLE);
    assign rd_valid    = (r_state == RESP);
    assign rd_data     = r_data;
    assign rd_err      = r_err;
    assign lock_status = r_lock;

`ifdef READ_AUDIT_EN
    logic [7:0] r_deny_count;
    logic       r_violation;

    always_ff @(posedge Clk) begin
        if (!resetn) begin
            r_deny_count <= '0;
            r_violation  <= 1'b0;
        end else if (r_state == CHECK && w_eff_lock) begin
            if (r_deny_count != 8'hFF) begin
                r_deny_count <= r_deny_count + 8'd1;
            end
            r_violation <= 1'b1;
        end
    end

    assign deny_count = r_deny_count;
    assign violation  = r_violation;
`endif

endmodule

// File: tb/tb_locked_reg_reader.sv
module tb_locked_reg_reader;

    logic        Clk = 1'b0;
    logic        resetn = 1'b0;
    logic [63:0] reg_data = '0;
    logic [3:0]  Lock = '0;
    logic        scan_mode = 1'b0;
    logic        debug_unlocked = 1'b0;
    logic        test_mode = 1'b0;
    logic        rd_req = 1'b0;
    logic [1:0]  rd_addr = '0;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_err;
    logic        rd_ack = 1'b0;
    logic [3:0]  lock_status;
`ifdef READ_AUDIT_EN
    logic [7:0]  deny_count;
    logic        violation;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: lock set, and number of denied reads since reset.
    logic [3:0] model_lock = '0;
    int         model_deny = 0;

    always #5 Clk = ~Clk;

    locked_reg_reader #(.DATA_W(16), .NUM_REGS(4)) dut (
        .Clk            (Clk),
        .resetn         (resetn),
        .reg_data       (reg_data),
        .Lock           (Lock),
        .scan_mode      (scan_mode),
        .debug_unlocked (debug_unlocked),
        .test_mode      (test_mode),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_err         (rd_err),
        .rd_ack         (rd_ack),
        .lock_status    (lock_status)
`ifdef READ_AUDIT_EN
        ,
        .deny_count     (deny_count),
        .violation      (violation)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock. The model takes the inputs currently applied, then
    // outputs are sampled 1ns after the edge.
    task automatic step();
        if (!resetn) begin
            model_lock = '0;
            model_deny = 0;
        end else begin
            model_lock = model_lock | Lock;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(rd_ready), 32'd1);
        check({tag, "_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_data"},  32'(rd_data),  32'd0);
        check({tag, "_err"},   32'(rd_err),   32'd0);
        check({tag, "_lock"},  32'(lock_status), 32'(model_lock));
`ifdef READ_AUDIT_EN
        check({tag, "_deny"},  32'(deny_count), 32'(model_deny));
        check({tag, "_viol"},  32'(violation),  32'(model_deny != 0));
`endif
    endtask

    // One complete read: accept, check, RESP held for ack_wait cycles, ack.
    task automatic do_read(input int addr, input int ack_wait, input logic [3:0] chk_lock);
        logic        locked;
        logic [15:0] exp_data;
        check_idle("pre");
        rd_req  = 1'b1;
        rd_addr = 2'(addr);
        step();
        // CHECK cycle: request/ack here must be ignored
        rd_req = 1'($urandom_range(0, 1));
        rd_ack = 1'($urandom_range(0, 1));
        Lock   = chk_lock;
        check("chk_ready", 32'(rd_ready), 32'd0);
        check("chk_valid", 32'(rd_valid), 32'd0);
        locked   = model_lock[addr] | chk_lock[addr];
        exp_data = locked ? 16'h0000 : reg_data[addr*16 +: 16];
        if (locked && model_deny < 255) model_deny++;
        step();
        Lock   = '0;
        rd_ack = 1'b0;
        for (int k = 0; k < ack_wait; k++) begin
            check("hold_valid", 32'(rd_valid), 32'd1);
            check("hold_ready", 32'(rd_ready), 32'd0);
            check("hold_data",  32'(rd_data),  32'(exp_data));
            check("hold_err",   32'(rd_err),   32'(locked));
            reg_data = {$urandom, $urandom};
            rd_req   = 1'($urandom_range(0, 1));
            rd_addr  = 2'($urandom_range(0, 3));
            step();
        end
        check("resp_valid", 32'(rd_valid), 32'd1);
        check("resp_data",  32'(rd_data),  32'(exp_data));
        check("resp_err",   32'(rd_err),   32'(locked));
        rd_ack = 1'b1;
        rd_req = 1'($urandom_range(0, 1));
        step();
        rd_ack = 1'b0;
        rd_req = 1'b0;
        check_idle("post");
        $display("txn addr=%0d wait=%0d locked=%0d data=0x%04h err=%0d", addr, ack_wait, locked, rd_data, rd_err);
    endtask

    initial begin
        // Reset
        resetn = 1'b0;
        step();
        step();
        check_idle("reset");
        resetn = 1'b1;
        step();

        // Unlocked read, immediate ack
        reg_data = 64'h1111_2222_A5A5_3333;
        do_read(1, 0, 4'b0000);
        check("a5a5_ready", 32'(rd_ready), 32'd1);

        // Lock pulse on register 2, then read it with all modes asserted
        Lock = 4'b0100;
        step();
        Lock = '0;
        scan_mode = 1'b1; debug_unlocked = 1'b1; test_mode = 1'b1;
        do_read(2, 1, 4'b0000);
        check("lock2_status", 32'(lock_status), 32'h4);
        scan_mode = 1'b0; debug_unlocked = 1'b0; test_mode = 1'b0;

        // Lock arriving during the check cycle denies the read
        do_read(3, 0, 4'b1000);

        // Long hold in RESP with changing inputs
        do_read(0, 5, 4'b0000);

        // Reset during RESP aborts the read and clears locks
        reg_data = 64'hBEEF_C0DE_1234_5678;
        rd_req = 1'b1; rd_addr = 2'd2;
        step();
        rd_req = 1'b0;
        step();
        check("abort_valid_pre", 32'(rd_valid), 32'd1);
        check("abort_err_pre",   32'(rd_err),   32'd1);
        resetn = 1'b0;
        step();
        check("abort_valid", 32'(rd_valid), 32'd0);
        check("abort_lock",  32'(lock_status), 32'd0);
        resetn = 1'b1;
        step();
        check("abort_ready", 32'(rd_ready), 32'd1);
        reg_data = 64'hBEEF_C0DE_1234_5678;
        do_read(2, 0, 4'b0000);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                resetn = 1'b0;
                step();
                resetn = 1'b1;
                check("rand_rst_lock", 32'(lock_status), 32'd0);
            end
            if ($urandom_range(0, 4) == 0) begin
                Lock = 4'(1 << $urandom_range(0, 3));
                step();
                Lock = '0;
            end
            {scan_mode, debug_unlocked, test_mode} = 3'($urandom);
            reg_data = {$urandom, $urandom};
            do_read($urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000);
        end

`ifdef READ_AUDIT_EN
        // Saturation of the deny counter, then reset
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        Lock = 4'b1111;
        step();
        Lock = '0;
        for (int t = 0; t < 260; t++) begin
            do_read(t % 4, 0, 4'b0000);
        end
        check("sat_deny", 32'(deny_count), 32'd255);
        check("sat_viol", 32'(violation),  32'd1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("sat_rst_deny", 32'(deny_count), 32'd0);
        check("sat_rst_viol", 32'(violation),  32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/locked_reg_reader.md
LOCKED_REG_READER -- requirements
Module: locked_reg_reader

Interface
REQ-001 Parameter: DATA_W, 16, width of each protected register.
REQ-002 Parameter: NUM_REGS, 4, number of protected registers (fixed; address is 2 bits).
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 reg_data  input  NUM_REGS*DATA_W  current register values; register i occupies bits [i*DATA_W +: DATA_W].
REQ-006 Lock  input  NUM_REGS  per-register lock request; bit i high for one or more cycles sets lock bit i.
REQ-007 scan_mode, debug_unlocked, test_mode  input  1 each  mode indicators; SHALL have no effect on any output.
REQ-008 rd_req  input  1  read request.
REQ-009 rd_addr  input  2  register index; sampled with rd_req.
REQ-010 rd_ready  output  1  high only in IDLE; a request is accepted when rd_req & rd_ready.
REQ-011 rd_valid  output  1  response valid.
REQ-012 rd_data  output  DATA_W  response data.
REQ-013 rd_err  output  1  response denied (register locked).
REQ-014 rd_ack  input  1  consumer accepts response when rd_valid & rd_ack.
REQ-015 lock_status  output  NUM_REGS  registered sticky lock bits.

Function
REQ-016 Lock bit i SHALL set on any cycle with Lock[i]=1 and SHALL clear only on reset; no other input clears it.
REQ-017 FSM SHALL have exactly three states: IDLE, CHECK, RESP.
REQ-018 IDLE: rd_ready=1; on rd_req=1 latch rd_addr, go to CHECK; else stay.
REQ-019 CHECK: effective lock = lock_status[addr] | Lock[addr] (a lock asserted in the CHECK cycle SHALL deny the read); if locked capture rd_data=0, rd_err=1, else rd_data=reg_data slice at CHECK cycle, rd_err=0; go to RESP.
REQ-020 RESP: rd_valid=1, rd_data/rd_err held stable; on rd_ack=1 go to IDLE next cycle; else stay.
REQ-021 Latency: accept at cycle N, rd_valid high from cycle N+2; earliest next accept at cycle N+3 for ack at N+2.
REQ-022 rd_req outside IDLE SHALL be ignored (no queueing).
REQ-023 rd_ack outside RESP SHALL be ignored.
REQ-024 After a response completes, rd_valid=0, rd_err=0 and rd_data=0 in IDLE.
REQ-025 Locked-register data SHALL never reach rd_data in any state, irrespective of scan_mode, debug_unlocked or test_mode.

Reset
REQ-026 resetn=0 at a posedge SHALL force: state IDLE, lock_status=0, rd_valid=0, rd_data=0, rd_err=0, latched address=0.
REQ-027 Reset in CHECK or RESP SHALL abort the transaction with no response; rd_ready=1 on the first cycle after resetn returns high.

Configuration
REQ-028 Macro READ_AUDIT_EN: when defined, add outputs deny_count (8 bits) and violation (1 bit).
REQ-029 With READ_AUDIT_EN: deny_count increments by 1 on each CHECK cycle resulting in rd_err=1, saturates at 255; violation sets on first denial, sticky; both cleared only by reset.
REQ-030 Without READ_AUDIT_EN: no audit ports or logic; all other behaviour identical.

Verification
REQ-031 Reset, reg_data slice 1=16'hA5A5, unlocked, read addr 1, ack immediately -> rd_valid at +2 cycles, rd_data=16'hA5A5, rd_err=0, rd_ready again at +3.
REQ-032 Pulse Lock[2] one cycle, then read addr 2 with scan_mode=debug_unlocked=test_mode=1 -> rd_data=16'h0000, rd_err=1; lock_status=4'b0100 persists.
REQ-033 Accept read addr 3, assert Lock[3] in CHECK cycle -> rd_err=1, rd_data=0.
REQ-034 Hold rd_ack=0 for 5 cycles in RESP while changing reg_data and pulsing rd_req -> rd_data/rd_err unchanged, no second accept; ack -> IDLE next cycle.
REQ-035 resetn low during RESP -> rd_valid=0, lock_status=0 next cycle; prior locked register now reads its data.
REQ-036 With READ_AUDIT_EN, 260 denied reads -> deny_count=255, violation=1; reset -> both 0.
